// File: rtl/instr_packer.sv
`default_nettype none
// ============================================================================
// Module      : instr_packer
// Description : Packs a stream of mixed 16-bit (compressed) and 32-bit
//               instructions into aligned 32-bit words with byte addresses.
//               Straddling instructions are split across consecutive words.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_packer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] base_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        drain_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [31:0] out_addr_o,
  output logic        idle_o
);

  // Upper half used when a pending halfword is padded out by a drain (C.NOP).
  localparam logic [15:0] C_CNOP = 16'h0001;

  logic        r_half;
  logic [15:0] r_half_data;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [31:0] r_out_addr;
  logic [31:0] r_addr;

  logic        w_out_free;
  logic        w_accept;
  logic        w_compressed;
  logic        w_drain_go;
  logic        w_load;
  logic [31:0] w_load_data;
  logic        w_half_nxt;
  logic [15:0] w_half_data_nxt;

  // The output slot can take a new word when empty or being emptied this cycle.
  assign w_out_free   = !r_out_valid || out_ready_i;
  assign in_ready_o   = !drain_i && !flush_i && w_out_free;
  assign w_accept     = in_valid_i && in_ready_o;
  assign w_compressed = (in_instr_i[1:0] != 2'b11);
  // Drain pads only when something is pending; a flush in the same cycle wins.
  assign w_drain_go   = drain_i && !flush_i && r_half && w_out_free;

  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out_data;
  assign out_addr_o   = r_out_addr;
  assign idle_o       = !r_half && !r_out_valid;

  // Decide what (if anything) goes into the output word and the new halfword state.
  always_comb begin
    w_load          = 1'b0;
    w_load_data     = 32'h0;
    w_half_nxt      = r_half;
    w_half_data_nxt = r_half_data;
    if (w_accept) begin
      if (!r_half) begin
        if (w_compressed) begin
          w_half_nxt      = 1'b1;
          w_half_data_nxt = in_instr_i[15:0];
        end else begin
          w_load      = 1'b1;
          w_load_data = in_instr_i;
        end
      end else begin
        w_load      = 1'b1;
        w_load_data = {in_instr_i[15:0], r_half_data};
        if (w_compressed) begin
          w_half_nxt = 1'b0;
        end else begin
          // Upper half of a straddling 32-bit instruction starts the next word.
          w_half_nxt      = 1'b1;
          w_half_data_nxt = in_instr_i[31:16];
        end
      end
    end else if (w_drain_go) begin
      w_load      = 1'b1;
      w_load_data = {C_CNOP, r_half_data};
      w_half_nxt  = 1'b0;
    end
  end

  // Pending-halfword, output register and address counter; flush overrides all.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_half      <= 1'b0;
      r_half_data <= 16'h0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0;
      r_out_addr  <= 32'h0;
      r_addr      <= RESET_ADDR;
    end else if (flush_i) begin
      r_half      <= 1'b0;
      r_out_valid <= 1'b0;
      r_addr      <= base_addr_i;
    end else begin
      r_half      <= w_half_nxt;
      r_half_data <= w_half_data_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_out_addr  <= r_addr;
        r_addr      <= r_addr + 32'd4;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_packer
// Description : Directed self-checking bench for instr_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_packer;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic [31:0] base_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic        drain_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [31:0] out_addr_o;
  logic        idle_o;

  int checks = 0;
  int errors = 0;

  instr_packer #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .base_addr_i (base_addr_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_instr_i  (in_instr_i),
    .drain_i     (drain_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_addr_o  (out_addr_o),
    .idle_o      (idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [31:0] a);
    chk({tag, "_valid"}, {31'h0, out_valid_o}, 32'h1);
    chk({tag, "_data"}, out_data_o, d);
    chk({tag, "_addr"}, out_addr_o, a);
  endtask

  initial begin
    rst_i       = 1'b0;
    flush_i     = 1'b0;
    base_addr_i = 32'h0;
    in_valid_i  = 1'b0;
    in_instr_i  = 32'h0;
    drain_i     = 1'b0;
    out_ready_i = 1'b1;
    #3;
    chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
    chk("rst_idle", {31'h0, idle_o}, 32'h1);
    chk("rst_ready", {31'h0, in_ready_o}, 32'h1);
    chk("rst_data", out_data_o, 32'h0);
    chk("rst_addr", out_addr_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Two compressed then one 32-bit
    in_valid_i = 1'b1; in_instr_i = 32'h0000_4501;
    cycle();
    chk("c1_nout", {31'h0, out_valid_o}, 32'h0);
    chk("c1_idle", {31'h0, idle_o}, 32'h0);
    in_instr_i = 32'h0000_8082;
    cycle();
    chk_word("w0", 32'h8082_4501, 32'h0000_0000);
    in_instr_i = 32'h00A0_0093;
    cycle();
    chk_word("w1", 32'h00A0_0093, 32'h0000_0004);
    in_valid_i = 1'b0;
    cycle();
    chk("w1_drop", {31'h0, out_valid_o}, 32'h0);
    chk("w1_idle", {31'h0, idle_o}, 32'h1);

    // Straddling 32-bit instruction
    in_valid_i = 1'b1; in_instr_i = 32'h0000_4501;
    cycle();
    in_instr_i = 32'h00A0_0093;
    cycle();
    chk_word("s0", 32'h0093_4501, 32'h0000_0008);
    in_instr_i = 32'h0000_8082;
    cycle();
    chk_word("s1", 32'h8082_00A0, 32'h0000_000C);
    in_valid_i = 1'b0;
    cycle();
    chk("s_idle", {31'h0, idle_o}, 32'h1);

    // Drain of a pending halfword
    in_valid_i = 1'b1; in_instr_i = 32'h0000_4501;
    cycle();
    in_valid_i = 1'b0; drain_i = 1'b1;
    #1;
    chk("dr_rdy", {31'h0, in_ready_o}, 32'h0);
    cycle();
    chk_word("dr", 32'h0001_4501, 32'h0000_0010);
    chk("dr_rdy2", {31'h0, in_ready_o}, 32'h0);
    cycle();
    chk("dr_idle", {31'h0, idle_o}, 32'h1);
    chk("dr_nout", {31'h0, out_valid_o}, 32'h0);
    cycle();
    chk("dr_empty", {31'h0, out_valid_o}, 32'h0);
    drain_i = 1'b0;

    // Backpressure
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_instr_i = 32'h1234_5673;
    cycle();
    chk_word("bp0", 32'h1234_5673, 32'h0000_0014);
    in_instr_i = 32'hABCD_0013;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", {31'h0, in_ready_o}, 32'h0);
      cycle();
      chk_word("bp_hold", 32'h1234_5673, 32'h0000_0014);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_rel", {31'h0, in_ready_o}, 32'h1);
    cycle();
    chk_word("bp1", 32'hABCD_0013, 32'h0000_0018);
    in_valid_i = 1'b0;
    cycle();
    chk("bp_done", {31'h0, out_valid_o}, 32'h0);

    // Flush with pending halfword and address wrap
    in_valid_i = 1'b1; in_instr_i = 32'h0000_4501;
    cycle();
    in_valid_i = 1'b0; flush_i = 1'b1; base_addr_i = 32'hFFFF_FFFC;
    #1;
    chk("fl_rdy", {31'h0, in_ready_o}, 32'h0);
    cycle();
    flush_i = 1'b0;
    chk("fl_idle", {31'h0, idle_o}, 32'h1);
    in_valid_i = 1'b1; in_instr_i = 32'h0000_0013;
    cycle();
    chk_word("fl0", 32'h0000_0013, 32'hFFFF_FFFC);
    in_instr_i = 32'h0010_0093;
    cycle();
    chk_word("fl1", 32'h0010_0093, 32'h0000_0000);
    in_valid_i = 1'b0;
    cycle();

    // Asynchronous reset mid-stream
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_instr_i = 32'h0000_4501;
    cycle();
    in_instr_i = 32'h1111_1113;
    cycle();
    chk_word("ar0", 32'h1113_4501, 32'h0000_0004);
    in_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("ar_valid", {31'h0, out_valid_o}, 32'h0);
    chk("ar_idle", {31'h0, idle_o}, 32'h1);
    chk("ar_data", out_data_o, 32'h0);
    chk("ar_addr", out_addr_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_instr_i = 32'h0000_0013;
    cycle();
    chk_word("ar1", 32'h0000_0013, 32'h0000_0000);
    in_valid_i = 1'b0;
    cycle();
    chk("ar_end_idle", {31'h0, idle_o}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
